// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one CW-bit chunk adder among N requesters for W-bit adds.
// Optional build macro SERIAL_ADD_EARLY_EXIT_EN ends a run once the remaining chunks and the carry are all zero.
module serial_add_sched #(
    parameter int N   = 4,
    parameter int W   = 256,
    parameter int CW  = 32,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    input  logic [N-1:0]     cin_in,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [W-1:0]     sum,
    output logic             cout
);

    localparam int NCH = W / CW;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  id_reg;
    logic [IDW-1:0]  done_id_reg;
    logic [KW-1:0]   k_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    acc_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic            cout_reg;

    logic [W-1:0]    a_arr [N];
    logic [W-1:0]    b_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*W +: W];
            assign b_arr[gi] = b_in[gi*W +: W];
        end
    endgenerate

    // Round-robin search: first active request at or above the pointer, wrapping.
    logic [N-1:0]    gnt_next;
    logic [IDW-1:0]  win_idx;
    logic            win_valid;
    int              rr_idx;

    always_comb begin
        gnt_next  = '0;
        win_idx   = '0;
        win_valid = 1'b0;
        rr_idx    = 0;
        for (int off = 0; off < N; off++) begin
            rr_idx = int'(ptr_reg) + off;
            if (rr_idx >= N) begin
                rr_idx = rr_idx - N;
            end
            if (!win_valid && req[rr_idx]) begin
                win_valid = 1'b1;
                win_idx   = IDW'(rr_idx);
            end
        end
        if (win_valid) begin
            gnt_next[win_idx] = 1'b1;
        end
    end

    // Operand registers shift right each chunk, so the active chunk is always the low CW bits.
    logic [CW-1:0]   chunk_a;
    logic [CW-1:0]   chunk_b;
    logic [CW:0]     chunk_sum;
    logic [W-1:0]    acc_next;
    logic            last_chunk;
    logic            finish;

    assign chunk_a   = a_reg[CW-1:0];
    assign chunk_b   = b_reg[CW-1:0];
    assign chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CW{1'b0}}, carry_reg};

    always_comb begin
        acc_next = acc_reg;
        acc_next[k_reg*CW +: CW] = chunk_sum[CW-1:0];
    end

    assign last_chunk = (k_reg == KW'(NCH - 1));

`ifdef SERIAL_ADD_EARLY_EXIT_EN
    logic rest_zero;
    assign rest_zero = ((a_reg >> CW) == '0) && ((b_reg >> CW) == '0) && !chunk_sum[CW];
    assign finish    = last_chunk || rest_zero;
`else
    assign finish    = last_chunk;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            id_reg      <= '0;
            done_id_reg <= '0;
            k_reg       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            sum_reg     <= '0;
            carry_reg   <= 1'b0;
            cout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        a_reg     <= a_arr[win_idx];
                        b_reg     <= b_arr[win_idx];
                        carry_reg <= cin_in[win_idx];
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        id_reg    <= win_idx;
                        ptr_reg   <= (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_next;
                    carry_reg <= chunk_sum[CW];
                    a_reg     <= a_reg >> CW;
                    b_reg     <= b_reg >> CW;
                    k_reg     <= k_reg + KW'(1);
                    if (finish) begin
                        sum_reg     <= acc_next;
                        cout_reg    <= chunk_sum[CW];
                        done_id_reg <= id_reg;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Grant is only offered in IDLE and is forced low while reset is held.
    assign gnt     = (rst && state_reg == IDLE) ? gnt_next : '0;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign done_id = done_id_reg;
    assign sum     = sum_reg;
    assign cout    = cout_reg;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed testbench for serial_add_sched: arbitration order, chunked carry chain, latency and async reset.
module tb_serial_add_sched;

    localparam int N   = 4;
    localparam int W   = 256;
    localparam int CW  = 32;
    localparam int IDW = 2;
    localparam int NCH = W / CW;

`ifdef SERIAL_ADD_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     cin_in;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             done;
    logic [IDW-1:0]   done_id;
    logic [W-1:0]     sum;
    logic             cout;

    int checks = 0;
    int errors = 0;

    serial_add_sched #(.N(N), .W(W), .CW(CW), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        cin_in[i]      = c;
    endtask

    // Counts edges after the current point until done is seen; lat = -1 on timeout.
    task automatic wait_done(output int lat, output bit gnt_bad);
        lat     = -1;
        gnt_bad = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (gnt !== '0) gnt_bad = 1'b1;
            if (done === 1'b1) lat = c;
        end
        $display("txn id=%0d sum=%h cout=%b lat=%0d", done_id, sum, cout, lat);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req = '1;
        a_in = '0;
        b_in = '0;
        cin_in = '0;
        #2;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id got=%0d exp=0", done_id); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        req = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single;
        int lat;
        bit gb;
        @(posedge clk); #1;
        set_op(0, 256'd5, 256'd7, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        @(posedge clk); #1;
        req = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        wait_done(lat, gb);
        checks++; if (lat !== (EE ? 1 : NCH)) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, EE ? 1 : NCH); end
        checks++; if (sum !== 256'd13) begin errors++; $display("FAIL single_sum got=%h exp=13", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL single_cout got=%b exp=0", cout); end
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL single_done_id got=%0d exp=0", done_id); end
        checks++; if (gb !== 1'b0) begin errors++; $display("FAIL single_gnt_while_busy got=1 exp=0"); end
    endtask

    task automatic test_carry_chain;
        int lat;
        bit gb;
        logic [W-1:0] ones;
        ones = '1;
        // Carry out of chunk 0 into chunk 1.
        @(posedge clk); #1;
        set_op(0, 256'hFFFF_FFFF, 256'd1, 1'b0);
        req = 4'b0001;
        @(posedge clk); #1;
        req = '0;
        wait_done(lat, gb);
        checks++; if (sum !== 256'h1_0000_0000) begin errors++; $display("FAIL chain32_sum got=%h exp=100000000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL chain32_cout got=%b exp=0", cout); end
        checks++; if (lat !== (EE ? 2 : NCH)) begin errors++; $display("FAIL chain32_latency got=%0d exp=%0d", lat, EE ? 2 : NCH); end
        // Carry rippling through every chunk.
        @(posedge clk); #1;
        set_op(2, ones, 256'd0, 1'b1);
        req = 4'b0100;
        @(posedge clk); #1;
        req = '0;
        wait_done(lat, gb);
        checks++; if (sum !== '0) begin errors++; $display("FAIL chainfull_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL chainfull_cout got=%b exp=1", cout); end
        checks++; if (done_id !== 2'd2) begin errors++; $display("FAIL chainfull_done_id got=%0d exp=2", done_id); end
        checks++; if (lat !== NCH) begin errors++; $display("FAIL chainfull_latency got=%0d exp=%0d", lat, NCH); end
    endtask

    task automatic test_early_exit;
        int lat;
        bit gb;
        @(posedge clk); #1;
        set_op(3, 256'd3, 256'd4, 1'b0);
        req = 4'b1000;
        @(posedge clk); #1;
        req = '0;
        wait_done(lat, gb);
        checks++; if (sum !== 256'd7) begin errors++; $display("FAIL early_sum got=%h exp=7", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL early_cout got=%b exp=0", cout); end
        checks++; if (lat !== (EE ? 1 : NCH)) begin errors++; $display("FAIL early_latency got=%0d exp=%0d", lat, EE ? 1 : NCH); end
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        int exp_sum [4] = '{16, 21, 24, 29};
        logic [N-1:0] one_hot;
        logic [N-1:0] exp_g;
        int cyc, ng, nd, last_g;
        // Fresh reset so the pointer starts at 0.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_op(i, W'(16 + i), W'(3 * i), i[0]);
        end
        @(posedge clk); #1;
        req = 4'b1111;
        one_hot = 1;
        cyc = 0; ng = 0; nd = 0; last_g = 0;
        while (nd < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                $display("txn id=%0d sum=%h cout=%b", done_id, sum, cout);
                checks++; if (done_id !== IDW'(order[nd])) begin errors++; $display("FAIL rr_done_id got=%0d exp=%0d", done_id, order[nd]); end
                checks++; if (sum !== W'(exp_sum[order[nd]])) begin errors++; $display("FAIL rr_sum got=%h exp=%0d", sum, exp_sum[order[nd]]); end
                nd++;
            end
            if (busy === 1'b1) begin
                checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gnt_busy got=%b exp=0000", gnt); end
            end else if (gnt !== 4'b0000) begin
                if (ng < 5) begin
                    exp_g = one_hot << order[ng];
                    checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_grant got=%b exp=%b", gnt, exp_g); end
                    if (ng > 0) begin
                        checks++; if ((cyc - last_g) !== ((EE ? 1 : NCH) + 2)) begin errors++; $display("FAIL rr_spacing got=%0d exp=%0d", cyc - last_g, (EE ? 1 : NCH) + 2); end
                    end
                    last_g = cyc;
                    ng++;
                    if (ng == 5) begin
                        @(posedge clk); #1;
                        req = '0;
                    end
                end else begin
                    checks++; errors++; $display("FAIL rr_extra_grant got=%b exp=0000", gnt);
                end
            end
        end
        checks++; if (nd !== 5) begin errors++; $display("FAIL rr_completions got=%0d exp=5", nd); end
    endtask

    task automatic test_drop_req;
        int lat;
        bit gb;
        logic [W-1:0] ones;
        ones = '1;
        @(posedge clk); #1;
        set_op(1, ones, 256'd0, 1'b0);
        set_op(2, 256'd7, 256'd7, 1'b0);
        set_op(3, 256'd50, 256'd50, 1'b1);
        req = 4'b1010;
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_first_gnt got=%b exp=0010", gnt); end
        @(posedge clk); #1;
        req = 4'b1100;
        @(posedge clk); #1;
        req = 4'b1000;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_gnt_busy got=%b exp=0000", gnt); end
        wait_done(lat, gb);
        checks++; if (done_id !== 2'd1) begin errors++; $display("FAIL drop_first_id got=%0d exp=1", done_id); end
        checks++; if (sum !== ones) begin errors++; $display("FAIL drop_first_sum got=%h exp=all ones", sum); end
        checks++; if (gb !== 1'b0) begin errors++; $display("FAIL drop_gnt_while_busy got=1 exp=0"); end
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_second_gnt got=%b exp=1000", gnt); end
        @(posedge clk); #1;
        req = '0;
        wait_done(lat, gb);
        checks++; if (done_id !== 2'd3) begin errors++; $display("FAIL drop_second_id got=%0d exp=3", done_id); end
        checks++; if (sum !== 256'd101) begin errors++; $display("FAIL drop_second_sum got=%h exp=101", sum); end
        repeat (4) begin
            @(negedge clk);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_unserved_gnt got=%b exp=0000", gnt); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_unserved_busy got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset;
        int lat;
        bit gb;
        logic [W-1:0] ones;
        ones = '1;
        @(posedge clk); #1;
        set_op(0, ones, 256'd0, 1'b1);
        req = 4'b0001;
        @(posedge clk); #1;
        req = '0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        req = 4'b0101;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL areset_done_id got=%0d exp=0", done_id); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL areset_sum got=%h exp=0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL areset_cout got=%b exp=0", cout); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL areset_gnt got=%b exp=0000", gnt); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", done); end
        end
        set_op(0, 256'd100, 256'd23, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL areset_ptr_gnt got=%b exp=0001", gnt); end
        @(posedge clk); #1;
        req = '0;
        wait_done(lat, gb);
        checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL areset_after_id got=%0d exp=0", done_id); end
        checks++; if (sum !== 256'd123) begin errors++; $display("FAIL areset_after_sum got=%h exp=123", sum); end
        checks++; if (lat !== (EE ? 1 : NCH)) begin errors++; $display("FAIL areset_after_latency got=%0d exp=%0d", lat, EE ? 1 : NCH); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry_chain();
        test_early_exit();
        test_round_robin();
        test_drop_req();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
